// File: rtl/jtframe_rom_arb_if.sv
// rtl/jtframe_rom_arb_if.sv - ROM client and SDRAM read-port bundle for jtframe_rom_arb
interface jtframe_rom_arb_if #(
    parameter int AW = 22,
    parameter int DW = 32
);
    logic [3:0]      slot_req;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_ok;
    logic [4*DW-1:0] slot_dout;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack;
    logic            data_rdy;
    logic [DW-1:0]   data_read;
    logic            refresh_en;

    // master is the arbiter; slave is the surrounding clients plus SDRAM controller
    modport master (
        input  slot_req, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );

    modport slave (
        output slot_req, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
endinterface

// File: rtl/jtframe_rom_arb.sv
// rtl/jtframe_rom_arb.sv - four-client round-robin SDRAM read arbiter with one-entry cache per client
module jtframe_rom_arb #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    jtframe_rom_arb_if.master     bus
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t        state;
    logic [1:0]    cur;
    logic [AW-1:0] tag   [4];
    logic [DW-1:0] dout  [4];
    logic [3:0]    valid;
    logic [3:0]    hit;
    logic [3:0]    pending;
    logic          busy;
    logic          found;
    logic [1:0]    nxt;
    logic [1:0]    idx;
    logic          sdram_req_r;
    logic [AW-1:0] sdram_addr_r;

    assign busy = (state != IDLE);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]     = valid[i] && (tag[i] == bus.slot_addr[i*AW +: AW]);
            // the slot being served is not pending again even if its address moved
            pending[i] = bus.slot_req[i] && !hit[i] && !(busy && (cur == 2'(i)));
        end
    end

    // round-robin search starting just after the last served slot
    always_comb begin
        found = 1'b0;
        nxt   = cur;
        idx   = cur;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur          <= 2'd3;
            valid        <= '0;
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= '0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                dout[i] <= '0;
            end
        end else if (downloading) begin
            state       <= IDLE;
            sdram_req_r <= 1'b0;
            valid       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur          <= nxt;
                        tag[nxt]     <= bus.slot_addr[nxt*AW +: AW];
                        valid[nxt]   <= 1'b0;
                        sdram_addr_r <= bus.slot_addr[nxt*AW +: AW];
                        sdram_req_r  <= 1'b1;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.sdram_ack) begin
                        sdram_req_r <= 1'b0;
                        if (bus.data_rdy) begin
                            dout[cur]  <= bus.data_read;
                            valid[cur] <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (bus.data_rdy) begin
                        dout[cur]  <= bus.data_read;
                        valid[cur] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sdram_req  = sdram_req_r;
    assign bus.sdram_addr = sdram_addr_r;
    assign bus.slot_ok    = bus.slot_req & hit;
    assign bus.refresh_en = (state == IDLE) && !(|pending);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.slot_dout[i*DW +: DW] = dout[i];
        end
    end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb/tb_jtframe_rom_arb.sv - directed self-checking bench for jtframe_rom_arb
module tb_jtframe_rom_arb;
    localparam int AW = 22;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    logic downloading;
    int   pass_cnt;
    int   total_cnt;

    jtframe_rom_arb_if #(.AW(AW), .DW(DW)) bus ();

    jtframe_rom_arb #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dout_of(input int i);
        return bus.slot_dout[i*DW +: DW];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        bus.slot_addr[i*AW +: AW] = a;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!bus.sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " req"}, 64'(bus.sdram_req), 64'd1);
    endtask

    // controller model: accept, spend one cycle, then return data
    task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input logic [DW-1:0] data);
        wait_req(tag);
        chk({tag, " addr"}, 64'(bus.sdram_addr), 64'(exp_addr));
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        chk({tag, " req drop"}, 64'(bus.sdram_req), 64'd0);
        tick();
        bus.data_rdy  = 1'b1;
        bus.data_read = data;
        tick();
        bus.data_rdy  = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        downloading    = 1'b0;
        bus.slot_req   = '0;
        bus.slot_addr  = '0;
        bus.sdram_ack  = 1'b0;
        bus.data_rdy   = 1'b0;
        bus.data_read  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        // reset state
        rst_n          = 1'b0;
        downloading    = 1'b0;
        bus.slot_req   = '0;
        bus.slot_addr  = '0;
        bus.sdram_ack  = 1'b0;
        bus.data_rdy   = 1'b0;
        bus.data_read  = '0;
        tick();
        tick();
        chk("rst sdram_req", 64'(bus.sdram_req), 64'd0);
        chk("rst sdram_addr", 64'(bus.sdram_addr), 64'd0);
        chk("rst slot_ok", 64'(bus.slot_ok), 64'd0);
        chk("rst slot_dout", 64'(bus.slot_dout[63:0]), 64'd0);
        chk("rst refresh_en", 64'(bus.refresh_en), 64'd1);
        rst_n = 1'b1;
        tick();

        // single miss, cycle 0 here
        bus.slot_req = 4'b0001;
        set_addr(0, 22'h00123);
        #1;
        chk("miss c0 refresh_en", 64'(bus.refresh_en), 64'd0);
        chk("miss c0 req", 64'(bus.sdram_req), 64'd0);
        tick();
        chk("miss c1 req", 64'(bus.sdram_req), 64'd1);
        chk("miss c1 addr", 64'(bus.sdram_addr), 64'h123);
        tick();
        chk("miss c2 req", 64'(bus.sdram_req), 64'd1);
        tick();
        chk("miss c3 req", 64'(bus.sdram_req), 64'd1);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        chk("miss c4 req", 64'(bus.sdram_req), 64'd0);
        tick();
        tick();
        chk("miss c6 ok", 64'(bus.slot_ok), 64'd0);
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hDEADBEEF;
        tick();
        bus.data_rdy = 1'b0;
        chk("miss c7 ok", 64'(bus.slot_ok), 64'b0001);
        chk("miss c7 dout0", 64'(dout_of(0)), 64'hDEADBEEF);
        chk("miss c7 refresh_en", 64'(bus.refresh_en), 64'd1);
        chk("miss c7 addr stable", 64'(bus.sdram_addr), 64'h123);

        // hit
        bus.slot_req = 4'b0000;
        #1;
        chk("hit drop ok", 64'(bus.slot_ok), 64'd0);
        bus.slot_req = 4'b0001;
        #1;
        chk("hit ok", 64'(bus.slot_ok), 64'b0001);
        tick();
        chk("hit no req a", 64'(bus.sdram_req), 64'd0);
        tick();
        chk("hit no req b", 64'(bus.sdram_req), 64'd0);
        chk("hit refresh_en", 64'(bus.refresh_en), 64'd1);

        // round-robin from a fresh reset
        reset_dut();
        set_addr(0, 22'h200);
        set_addr(1, 22'h201);
        set_addr(2, 22'h202);
        set_addr(3, 22'h203);
        bus.slot_req = 4'b1111;
        serve("rr0", 22'h200, 32'hA0000000);
        chk("rr0 ok", 64'(bus.slot_ok[0]), 64'd1);
        chk("rr0 dout", 64'(dout_of(0)), 64'hA0000000);
        serve("rr1", 22'h201, 32'hA0000001);
        chk("rr1 dout", 64'(dout_of(1)), 64'hA0000001);
        serve("rr2", 22'h202, 32'hA0000002);
        chk("rr2 dout", 64'(dout_of(2)), 64'hA0000002);
        serve("rr3", 22'h203, 32'hA0000003);
        chk("rr3 dout", 64'(dout_of(3)), 64'hA0000003);
        chk("rr all ok", 64'(bus.slot_ok), 64'hF);
        chk("rr dout0 kept", 64'(dout_of(0)), 64'hA0000000);

        // address change while in WAIT_RDY
        bus.slot_req = 4'b0010;
        set_addr(1, 22'h10);
        wait_req("chg");
        chk("chg addr", 64'(bus.sdram_addr), 64'h10);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        set_addr(1, 22'h20);
        #1;
        chk("chg ok mid", 64'(bus.slot_ok[1]), 64'd0);
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h10101010;
        tick();
        bus.data_rdy = 1'b0;
        chk("chg ok after rdy", 64'(bus.slot_ok[1]), 64'd0);
        serve("chg refetch", 22'h20, 32'h20202020);
        chk("chg ok new", 64'(bus.slot_ok[1]), 64'd1);
        chk("chg dout new", 64'(dout_of(1)), 64'h20202020);

        // download abort during WAIT_ACK
        bus.slot_req = 4'b0001;
        set_addr(0, 22'h300);
        wait_req("dl");
        chk("dl addr", 64'(bus.sdram_addr), 64'h300);
        downloading = 1'b1;
        tick();
        chk("dl req", 64'(bus.sdram_req), 64'd0);
        chk("dl ok", 64'(bus.slot_ok), 64'd0);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h0BAD0BAD;
        tick();
        bus.data_rdy = 1'b0;
        chk("dl stray dout0", 64'(dout_of(0)), 64'hA0000000);
        chk("dl stray dout1", 64'(dout_of(1)), 64'h20202020);
        chk("dl stray dout2", 64'(dout_of(2)), 64'hA0000002);
        chk("dl stray dout3", 64'(dout_of(3)), 64'hA0000003);
        chk("dl stray ok", 64'(bus.slot_ok), 64'd0);
        chk("dl hold req", 64'(bus.sdram_req), 64'd0);
        downloading = 1'b0;
        serve("dl refetch", 22'h300, 32'h30303030);
        chk("dl refetch ok", 64'(bus.slot_ok), 64'b0001);
        chk("dl refetch dout", 64'(dout_of(0)), 64'h30303030);

        // async reset in WAIT_RDY
        bus.slot_req = 4'b0100;
        set_addr(2, 22'h400);
        wait_req("ar");
        chk("ar addr", 64'(bus.sdram_addr), 64'h400);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.slot_req  = 4'b0101;
        set_addr(0, 22'h500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar req", 64'(bus.sdram_req), 64'd0);
        chk("ar ok", 64'(bus.slot_ok), 64'd0);
        chk("ar dout0", 64'(dout_of(0)), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        serve("ar first", 22'h500, 32'h50505050);
        chk("ar first ok", 64'(bus.slot_ok), 64'b0001);
        serve("ar second", 22'h400, 32'h40404040);
        chk("ar second ok", 64'(bus.slot_ok), 64'b0101);
        chk("ar second dout", 64'(dout_of(2)), 64'h40404040);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
